// File: rtl/gamecube_bus_transceiver.sv
// rtl/gamecube_bus_transceiver.sv - GameCube single-wire bus frame transceiver, open-drain DATALINE
// Optional TX bus-fight detection is compiled in when GC_XCVR_COLLISION_EN is defined.
module gamecube_bus_transceiver #(
    parameter int CYCLES_PER_US = 50,
    parameter int MAX_TX_BYTES  = 3,
    parameter int MAX_RX_BYTES  = 8,
    parameter int RX_TIMEOUT_US = 100
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 START,
    input  logic [8*MAX_TX_BYTES-1:0]            TX_FRAME,
    input  logic [$clog2(MAX_TX_BYTES+1)-1:0]    TX_LEN,
    input  logic [$clog2(MAX_RX_BYTES+1)-1:0]    RX_LEN,
    output logic                                 BUSY,
    output logic                                 DONE,
    output logic                                 TIMEOUT,
    output logic                                 COLLISION,
    output logic [8*MAX_RX_BYTES-1:0]            RX_FRAME,
    output logic [$clog2(MAX_RX_BYTES+1)-1:0]    RX_COUNT,
    inout  wire                                  DATALINE
);
    localparam int C         = CYCLES_PER_US;
    localparam int TO_CYCLES = RX_TIMEOUT_US * C;
    localparam int CNT_MAX   = (TO_CYCLES > 4*C) ? TO_CYCLES : 4*C;
    localparam int CW        = $clog2(CNT_MAX);
    localparam int TLW       = $clog2(MAX_TX_BYTES + 1);
    localparam int RLW       = $clog2(MAX_RX_BYTES + 1);

    localparam logic [CW-1:0]  ONE_C     = CW'(C);
    localparam logic [CW-1:0]  THREE_C   = CW'(3*C);
    localparam logic [CW-1:0]  C_LAST    = CW'(C - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(4*C - 1);
    localparam logic [CW-1:0]  SAMPLE_AT = CW'(2*C - 1);
    localparam logic [CW-1:0]  TO_LAST   = CW'(TO_CYCLES - 1);
    localparam logic [TLW-1:0] TX_MAX    = TLW'(MAX_TX_BYTES);
    localparam logic [RLW-1:0] RX_MAX    = RLW'(MAX_RX_BYTES);

    typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, FINISH} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    drive_low;
    logic [8*MAX_TX_BYTES-1:0] tx_buf;
    logic [TLW-1:0]          tx_len_q;
    logic [TLW-1:0]          tx_byte;
    logic [2:0]              tx_pos;
    logic [RLW-1:0]          rx_len_q;
    logic [2:0]              rx_pos;
    logic [7:0]              rx_shift;
    logic                    rx_stop;
    logic                    dl_s1, dl_s2, dl_s3;
    logic                    tx_cur;
    logic                    fall;
    logic [CW-1:0]           tx_low_len;

    assign DATALINE   = drive_low ? 1'b0 : 1'bz;
    // Bits go MSB-first within a byte, so the in-byte position is inverted.
    assign tx_cur     = tx_buf[{tx_byte, ~tx_pos}];
    assign tx_low_len = tx_cur ? ONE_C : THREE_C;
    assign fall       = dl_s3 & ~dl_s2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dl_s1 <= 1'b1;
            dl_s2 <= 1'b1;
            dl_s3 <= 1'b1;
        end else begin
            dl_s1 <= DATALINE;
            dl_s2 <= dl_s1;
            dl_s3 <= dl_s2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            drive_low <= 1'b0;
            tx_buf    <= '0;
            tx_len_q  <= '0;
            tx_byte   <= '0;
            tx_pos    <= '0;
            rx_len_q  <= '0;
            rx_pos    <= '0;
            rx_shift  <= '0;
            rx_stop   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
            COLLISION <= 1'b0;
            RX_FRAME  <= '0;
            RX_COUNT  <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && TX_LEN != '0 && TX_LEN <= TX_MAX) begin
                        tx_buf    <= TX_FRAME;
                        tx_len_q  <= TX_LEN;
                        rx_len_q  <= (RX_LEN > RX_MAX) ? RX_MAX : RX_LEN;
                        RX_FRAME  <= '0;
                        RX_COUNT  <= '0;
                        TIMEOUT   <= 1'b0;
                        COLLISION <= 1'b0;
                        BUSY      <= 1'b1;
                        drive_low <= 1'b1;
                        cnt       <= '0;
                        tx_byte   <= '0;
                        tx_pos    <= '0;
                        rx_pos    <= '0;
                        rx_stop   <= 1'b0;
                        state     <= TX_BIT;
                    end
                end
                TX_BIT: begin
`ifdef GC_XCVR_COLLISION_EN
                    // Two cycles of slack cover the synchroniser after our own release.
                    if (cnt >= tx_low_len + CW'(2) && !dl_s2) begin
                        COLLISION <= 1'b1;
                        drive_low <= 1'b0;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= FINISH;
                    end else
`endif
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        drive_low <= 1'b1;
                        if (tx_pos == 3'd7) begin
                            tx_pos  <= 3'd0;
                            tx_byte <= tx_byte + TLW'(1);
                            if (tx_byte == tx_len_q - TLW'(1))
                                state <= TX_STOP;
                        end else begin
                            tx_pos <= tx_pos + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == tx_low_len - CW'(1))
                            drive_low <= 1'b0;
                    end
                end
                TX_STOP: begin
                    if (cnt == C_LAST) begin
                        drive_low <= 1'b0;
                        cnt       <= '0;
                        state     <= RX_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_WAIT: begin
                    if (rx_len_q == '0) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FINISH;
                    end else if (fall) begin
                        cnt   <= '0;
                        state <= RX_BIT;
                    end else if (cnt == TO_LAST) begin
                        TIMEOUT <= 1'b1;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= FINISH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_BIT: begin
                    cnt <= cnt + CW'(1);
                    if (!rx_stop && cnt == SAMPLE_AT)
                        rx_shift <= {rx_shift[6:0], dl_s2};
                    if (dl_s2 && (rx_stop || cnt > SAMPLE_AT)) begin
                        if (rx_stop) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            cnt    <= '0;
                            rx_pos <= rx_pos + 3'd1;
                            state  <= RX_WAIT;
                            if (rx_pos == 3'd7) begin
                                for (int i = 0; i < MAX_RX_BYTES; i++)
                                    if (RX_COUNT == RLW'(i))
                                        RX_FRAME[8*i +: 8] <= rx_shift;
                                RX_COUNT <= RX_COUNT + RLW'(1);
                                if (RX_COUNT + RLW'(1) == rx_len_q)
                                    rx_stop <= 1'b1;
                            end
                        end
                    end else if (cnt == BIT_LAST) begin
                        TIMEOUT <= 1'b1;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gamecube_bus_transceiver.sv
// tb/tb_gamecube_bus_transceiver.sv - randomized bench with bus-level console/controller model
module tb_gamecube_bus_transceiver;
    localparam int C  = 50;
    localparam int TO = 100 * C;
`ifdef GC_XCVR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] tx_frame = '0;
    logic [1:0]  tx_len = '0;
    logic [3:0]  rx_len = '0;
    logic        busy, done, timeout, collision;
    logic [63:0] rx_frame;
    logic [3:0]  rx_count;
    wire         dl;
    logic        model_low = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          cyc = 0;

    pullup (dl);
    assign dl = model_low ? 1'b0 : 1'bz;

    gamecube_bus_transceiver dut (
        .CLK(clk), .RST(rst), .START(start), .TX_FRAME(tx_frame), .TX_LEN(tx_len),
        .RX_LEN(rx_len), .BUSY(busy), .DONE(done), .TIMEOUT(timeout),
        .COLLISION(collision), .RX_FRAME(rx_frame), .RX_COUNT(rx_count), .DATALINE(dl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = done;
    endtask

    task automatic send_bit(input bit v);
        model_low = 1'b1;
        repeat (v ? C : 3*C) @(negedge clk);
        model_low = 1'b0;
        repeat (v ? 3*C : C) @(negedge clk);
    endtask

    // tail: 0 = stop bit after resp_n bytes, 1 = silence, 2 = line held low
    task automatic run_frame(input string name, input logic [23:0] txf, input int txl,
                             input int rxl, input logic [63:0] resp, input int resp_n,
                             input int tail, input int poke_bit);
        logic [23:0] got, mask;
        logic [63:0] exp_frame;
        int lo, hi, terr, rel, lat, d0, exp_cnt, pos;
        bit ok, bv;
        d0 = done_cnt;
        start = 1'b1; tx_frame = txf; tx_len = 2'(txl); rx_len = 4'(rxl);
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_low"}, dl, 0);
        got = '0;
        terr = 0;
        for (int b = 0; b < txl*8; b++) begin
            pos = 8*(b/8) + 7 - (b%8);
            bv = txf[pos];
            if (b == poke_bit) begin
                start = 1'b1; tx_frame = ~txf; tx_len = 2'd1;
            end
            lo = 0;
            while (dl == 1'b0 && lo < 8*C) begin lo++; @(negedge clk); start = 1'b0; end
            hi = 0;
            while (dl == 1'b1 && hi < 8*C) begin hi++; @(negedge clk); end
            got[pos] = (lo < 2*C);
            if (lo != (bv ? C : 3*C) || hi != (bv ? 3*C : C)) terr++;
        end
        lo = 0;
        while (dl == 1'b0 && lo < 8*C) begin lo++; @(negedge clk); end
        if (lo != C) terr++;
        rel = cyc;
        mask = 24'hFFFFFF >> (8*(3 - txl));
        check({name, "_tx_bits"}, got, txf & mask);
        check({name, "_tx_timing_errs"}, terr, 0);

        if (rxl > 0) begin
            repeat ($urandom_range(2*C, 4)) @(negedge clk);
            for (int i = 0; i < resp_n; i++)
                for (int j = 7; j >= 0; j--)
                    send_bit(resp[8*i + j]);
            if (tail == 0) begin
                model_low = 1'b1;
                repeat (C) @(negedge clk);
                model_low = 1'b0;
            end else if (tail == 2) begin
                model_low = 1'b1;
            end
        end
        wait_done(TO + 40*C, ok);
        lat = cyc - rel;
        model_low = 1'b0;
        check({name, "_done_seen"}, ok, 1);

        exp_cnt = (resp_n < rxl) ? resp_n : rxl;
        exp_frame = '0;
        for (int i = 0; i < exp_cnt; i++) exp_frame[8*i +: 8] = resp[8*i +: 8];
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_timeout"}, timeout, (rxl != 0) && (tail != 0));
        check({name, "_collision"}, collision, 0);
        check({name, "_rx_count"}, rx_count, exp_cnt);
        check({name, "_rx_frame"}, rx_frame, exp_frame);
        if (rxl == 0)
            check({name, "_done_after_stop"}, (lat >= 1 && lat <= 3), 1);
        if (rxl > 0 && resp_n == 0 && tail == 1)
            check({name, "_timeout_latency"}, (lat >= TO && lat <= TO + 4), 1);
        @(negedge clk);
        check({name, "_done_width"}, done, 0);
        repeat (3) @(negedge clk);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_rx_count_hold"}, rx_count, exp_cnt);
    endtask

    initial begin
        int txl, rxl, pb, d0;
        logic [23:0] txf;
        logic [63:0] resp;
        bit ok, seen;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_collision", collision, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_rx_frame", rx_frame, 0);
        check("rst_dl", dl, 1);
        rst = 1'b0;
        @(negedge clk);

        start = 1'b1; tx_len = 2'd0; tx_frame = 24'h123456; rx_len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("len0_busy", busy, 0);
        check("len0_dl", dl, 1);

        run_frame("poll", 24'h020340, 3, 8, 64'h0706050403020100, 8, 0, -1);
        run_frame("noresp", 24'h000000, 1, 2, 64'h0, 0, 1, -1);
        run_frame("stuck", 24'h000041, 1, 5, 64'h0000000000A5C33C, 3, 2, -1);
        run_frame("rx0", 24'h00005A, 1, 0, 64'h0, 0, 0, -1);

        // Fight the line during the release phase of bit 5 (a '0') of 0x40.
        start = 1'b1; tx_frame = 24'h000040; tx_len = 2'd1; rx_len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (23*C + C/2) @(negedge clk);
        seen = 1'b0;
        model_low = 1'b1;
        for (int k = 0; k < C/4; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        model_low = 1'b0;
        if (!seen) begin
            wait_done(TO + 40*C, ok);
            seen = ok;
        end
        check("coll_done", seen, 1);
        check("coll_flag", collision, COLL_EN);
        check("coll_timeout", timeout, !COLL_EN);
        check("coll_rx_count", rx_count, 0);
        @(negedge clk);
        check("coll_dl_released", dl, 1);
        repeat (5) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            txl  = $urandom_range(3, 1);
            rxl  = $urandom_range(3, 1);
            txf  = 24'($urandom);
            resp = {$urandom, $urandom};
            pb   = $urandom_range(txl*8 - 1, 1);
            run_frame("rnd", txf, txl, rxl, resp, rxl, 0, pb);
        end

        d0 = done_cnt;
        start = 1'b1; tx_frame = 24'h0000A5; tx_len = 2'd1; rx_len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (2*C) @(negedge clk);
        start = 1'b1; tx_frame = 24'hFFFFFF; tx_len = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", busy, 1);
        repeat (3*C) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_dl", dl, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_timeout", timeout, 0);
        check("abort_rx_count", rx_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10*C) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_dl", dl, 1);
        check("abort_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gamecube_bus_transceiver.md
# gamecube_bus_transceiver

Parametrised, frame-level, open-drain transceiver for the GameCube controller single-wire bus. It serialises a host command of 1..MAX_TX_BYTES bytes with console bit timing and a stop bit. It then turns the line around and deserialises a 0..MAX_RX_BYTES controller response, with timeout and optional collision detection. It sits between the controller-polling logic and the DATALINE pad and replaces per-bit handshaking with a single START/DONE frame handshake.

## Interface
- CYCLES_PER_US, default 50: clock cycles per microsecond (C below); must be ≥ 4.
- MAX_TX_BYTES, default 3: command buffer depth in bytes.
- MAX_RX_BYTES, default 8: response buffer depth in bytes.
- RX_TIMEOUT_US, default 100: maximum wait, in µs, for any expected falling edge.

Ports:
- CLK  in  1: system clock.
- RST  in  1: reset, asynchronous, active-high.
- START  in  1: one-cycle frame request; honoured only in IDLE.
- TX_FRAME  in  8*MAX_TX_BYTES: command bytes; byte 0 = bits [7:0], sent first.
- TX_LEN  in  clog2(MAX_TX_BYTES+1): number of command bytes.
- RX_LEN  in  clog2(MAX_RX_BYTES+1): expected response bytes.
- BUSY  out  1: frame in progress.
- DONE  out  1: one-cycle pulse at frame end, success or failure.
- TIMEOUT  out  1: valid with DONE; response edge missing or line stuck low.
- COLLISION  out  1: valid with DONE; bus fought during TX (macro only, else 0).
- RX_FRAME  out  8*MAX_RX_BYTES: received bytes; byte 0 = bits [7:0].
- RX_COUNT  out  clog2(MAX_RX_BYTES+1): complete bytes received.
- DATALINE  inout  1: open-drain; drives 0 or Z, never 1.

## Operation
- States: IDLE → TX_BIT → TX_STOP → RX_WAIT ↔ RX_BIT → FINISH → IDLE.
- IDLE: DATALINE released. START with TX_LEN in 1..MAX_TX_BYTES latches TX_FRAME, TX_LEN and RX_LEN, clears RX_FRAME/RX_COUNT/flags and sets BUSY. START with TX_LEN=0 or TX_LEN>MAX is ignored.
- TX_BIT: bits sent MSB-first within each byte, byte 0 first. Bit '0' = low 3C cycles, released C. Bit '1' = low C cycles, released 3C.
- TX_STOP: low C cycles, then release; enter RX_WAIT. If RX_LEN=0, go to FINISH instead.
- RX path: DATALINE passes through a 2-flop synchroniser and falling edges are detected on the synchronised signal.
- RX_WAIT: waits for a falling edge, at most RX_TIMEOUT_US*C cycles; expiry → TIMEOUT=1, FINISH.
- RX_BIT: samples 2C cycles after the detected edge (high=1, low=0) and shifts MSB-first. It then waits for high; low lasting beyond 4C cycles from the edge → TIMEOUT, FINISH.
- After 8 bits, RX_COUNT increments. After RX_LEN bytes, one more falling edge (stop bit) is awaited, then its release; stop-bit timeout also sets TIMEOUT. RX_FRAME bytes stay valid once counted.
- FINISH: DONE=1 for one cycle, BUSY drops the same cycle, → IDLE. TIMEOUT, COLLISION, RX_FRAME and RX_COUNT hold until the next accepted START.

## Timing
- Reset: BUSY, DONE, TIMEOUT, COLLISION, RX_COUNT and RX_FRAME = 0; DATALINE released asynchronously with RST.
- START→first DATALINE low: 1 cycle. Each TX bit is exactly 4C cycles; the stop low is exactly C.
- Latency = TX_LEN*8*4C + C cycles plus response time; DONE follows the stop-bit release detection by 1 cycle.
- START while BUSY: ignored, with no effect on the frame. START in the DONE cycle: ignored.
- RST mid-frame: immediate abort, no DONE pulse.

## Configuration
- GC_XCVR_COLLISION_EN defined: during TX release phases, the synchronised line is checked from 2 cycles after release onward. A low sample sets COLLISION, releases the line and goes to FINISH (DONE pulse, no RX).
- Undefined: no check; COLLISION is constant 0.

## Test plan
- Poll 0x40,0x03,0x02 (TX_LEN=3, RX_LEN=8); bus model answers 8 bytes 0x00..0x07 → RX_FRAME bytes match, RX_COUNT=8, DONE once, TIMEOUT=0.
- Waveform check at C=50: '0' low 150 and released 50 cycles; '1' low 50 and released 150; stop low 50.
- No response from model → DONE exactly RX_TIMEOUT_US*C (+sync latency) cycles after release, TIMEOUT=1, RX_COUNT=0. Model stuck low after 3 bytes → TIMEOUT=1, RX_COUNT=3.
- With GC_XCVR_COLLISION_EN, model pulls low during the release phase of bit 5 → COLLISION=1, DONE, DATALINE released. Without the macro, COLLISION=0.
- START pulsed mid-frame, then RST mid-TX → second START ignored; after reset, DATALINE=Z, all outputs 0, no DONE.
- RX_LEN=0 with TX_LEN=1 → DONE 1 cycle after stop release, RX_COUNT=0.
